tag_lookup_ctrl_2way: RTL and testbench
=======================================

# tag_lookup_ctrl_2way

Lookup/allocate controller for the 2-way set-associative cache tag store. It sequences two synchronous-read tag RAMs (way 0 and way 1), compares the stored tags against a request address, and reports hit or miss. It chooses a victim with per-set LRU, writes the updated tag entry back, and zero-initialises both tag RAMs after reset. It sits between the cache request front-end and the `tagRam0`/`tagRam1` instances.

## Interface
- `AWIDTH`, default 3: set-index width; `DEPTH = 1 << AWIDTH` sets.
- `TWIDTH`, default 12: tag width.
- `DWIDTH`, localparam `TWIDTH+2`: tag RAM word, laid out as `{valid, dirty, tag[TWIDTH-1:0]}`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on the edge where `req_valid & req_ready`.
- `req_addr` in `TWIDTH+AWIDTH`: `{tag, index}`.
- `req_we` in 1: write access; sets dirty on the accessed line.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_hit` out 1: lookup hit.
- `resp_way` out 1: hit way, or the allocated way on a miss.
- `resp_evict_dirty` out 1: the victim was valid and dirty; write-back is needed.
- `resp_evict_tag` out `TWIDTH`: victim tag; 0 when `resp_evict_dirty=0`.
- `t0_addr`, `t1_addr` out `AWIDTH`: tag RAM addresses.
- `t0_din`, `t1_din` out `DWIDTH`: tag RAM write data.
- `t0_we`, `t1_we` out 1: tag RAM write enables.
- `t0_dout`, `t1_dout` in `DWIDTH`: tag RAM read data. Valid the cycle after its address is sampled.

## Operation
- States: INIT, IDLE, CMP.
- **Reset.** `reset=1` forces INIT from any state with `init_cnt=0` and all `lru[]` cleared. Any in-flight request is dropped with no `resp_valid`.
- **INIT.**
  - Each cycle: `t0_addr=t1_addr=init_cnt`, `t0_we=t1_we=1`, `t*_din=0`, `init_cnt` increments.
  - After writing `DEPTH-1`, go to IDLE.
  - INIT lasts exactly `DEPTH` cycles. `req_ready=0` throughout.
- **IDLE.**
  - `req_ready=1`.
  - `t*_addr` are driven combinationally from `req_addr` index, so the RAMs latch the index on the accept edge.
  - On accept: register tag, index and we, then go to CMP. Otherwise stay in IDLE.
- **CMP.**
  - `req_ready=0`; `t*_addr` = registered index.
  - `hitN = t{N}_dout.valid & (t{N}_dout.tag == reg_tag)`. If both ways hit (corrupt set), way 0 wins.
  - On hit:
    - `resp_hit=1`, `resp_way`=hit way.
    - If `we`: write `{1,1,tag}` to the hit way. Otherwise no RAM write.
    - Evict outputs are 0.
  - On miss, victim selection:
    - Way 0 if it is invalid.
    - Otherwise way 1 if it is invalid.
    - Otherwise `lru[index]`.
  - On miss, writeback of the victim:
    - Write `{1, we, tag}` to the victim way.
    - `resp_way`=victim.
    - `resp_evict_dirty` = victim valid & dirty; `resp_evict_tag` = victim tag.
  - LRU update on hit or allocate: `lru[index] <= ~resp_way`, i.e. the other way becomes LRU.
  - `resp_valid=1` for this cycle only. Always return to IDLE.
- **Output gating.** All `resp_*` outputs are 0 outside CMP. `t*_we` is 0 in IDLE.

## Timing
- Reset values: `req_ready=0`, `resp_*=0`, `t*_we=1` (INIT begins), `t*_addr=0`, `t*_din=0`.
- Latency: accept on edge k, `resp_valid` high during the cycle between edges k and k+1, and the RAM write commits on edge k+1.
- Throughput: one request per 2 cycles. `req_ready` is high only in IDLE.
- With `req_valid` held high, `req_ready` toggles 1,0,1,0.
- `resp_*` outputs are combinational from `t*_dout` and registered state within CMP. The consumer samples them on the edge ending CMP.
- No internal bypass is needed. The next lookup to the same set reads the RAM after the CMP write has committed.

## Test plan
- **Reset/INIT:** pulse `reset` for 1 cycle. Expect `t0_we=t1_we=1`, `din=0` at addresses 0..7 over 8 consecutive cycles, then `req_ready=1`.
- **Miss then hit:** read tag `0x0A5`, index 3.
  - Expect `resp_hit=0`, `resp_way=0`, `resp_evict_dirty=0`, and `t0_din=14'h20A5` written to address 3.
  - Repeat the request: `resp_hit=1`, `resp_way=0`, no RAM write.
- **Dirty eviction:** starting from the miss-then-hit state, issue three requests to index 3.
  - Write tag `0x111`: miss, way 1, writes `14'h3111`.
  - Read tag `0x222`: miss, victim way 0 (LRU), `resp_evict_dirty=0`.
  - Read tag `0x333`: victim way 1, `resp_evict_dirty=1`, `resp_evict_tag=0x111`.
- **Write hit:** write tag `0x0A5`, index 5 after it has been allocated clean in way 0. Expect `resp_hit=1` and `t0_din=14'h30A5`. `lru[5]` becomes 1.
- **Reset mid-op:** assert `reset` in the CMP cycle. Expect `resp_valid=0` on that edge, no request write, and 8 INIT cycles to follow. A subsequent lookup of the same address misses.
- **Back-to-back:** hold `req_valid=1` with 4 distinct sets. Expect `resp_valid` on alternate cycles, exactly 4 responses, each in request order.

Source files
------------

// File: rtl/tag_lookup_ctrl_2way.sv
// tag_lookup_ctrl_2way: lookup/allocate sequencer for a 2-way set-associative
// tag store. Zero-fills both tag RAMs after reset, then serves one request
// every two cycles: address the RAMs on accept, compare/allocate in CMP.
module tag_lookup_ctrl_2way #(
  parameter  int AWIDTH = 3,
  parameter  int TWIDTH = 12,
  localparam int DWIDTH = TWIDTH + 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TWIDTH+AWIDTH-1:0] req_addr,
  input  logic                     req_we,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic                     resp_way,
  output logic                     resp_evict_dirty,
  output logic [TWIDTH-1:0]        resp_evict_tag,
  output logic [AWIDTH-1:0]        t0_addr,
  output logic [AWIDTH-1:0]        t1_addr,
  output logic [DWIDTH-1:0]        t0_din,
  output logic [DWIDTH-1:0]        t1_din,
  output logic                     t0_we,
  output logic                     t1_we,
  input  logic [DWIDTH-1:0]        t0_dout,
  input  logic [DWIDTH-1:0]        t1_dout
);

  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CMP} state_t;

  state_t              r_state, w_next;
  logic [AWIDTH-1:0]   r_init_cnt;
  logic [DEPTH-1:0]    r_lru;     // per set: way to replace when both valid
  logic [TWIDTH-1:0]   r_tag;
  logic [AWIDTH-1:0]   r_idx;
  logic                r_we;

  // Unpack the two RAM words {valid, dirty, tag}
  logic              w_v0, w_v1, w_d0, w_d1;
  logic [TWIDTH-1:0] w_tag0, w_tag1;
  logic              w_hit0, w_hit1, w_hit, w_victim, w_way, w_vic_dirty;
  logic [TWIDTH-1:0] w_vic_tag;

  assign w_v0   = t0_dout[DWIDTH-1];
  assign w_d0   = t0_dout[DWIDTH-2];
  assign w_tag0 = t0_dout[TWIDTH-1:0];
  assign w_v1   = t1_dout[DWIDTH-1];
  assign w_d1   = t1_dout[DWIDTH-2];
  assign w_tag1 = t1_dout[TWIDTH-1:0];

  assign w_hit0 = w_v0 & (w_tag0 == r_tag);
  assign w_hit1 = w_v1 & (w_tag1 == r_tag);
  assign w_hit  = w_hit0 | w_hit1;

  // Fill an empty way first; only consult LRU when the set is full
  assign w_victim    = !w_v0 ? 1'b0 : (!w_v1 ? 1'b1 : r_lru[r_idx]);
  // Way 0 wins if a corrupt set hits in both ways
  assign w_way       = w_hit ? !w_hit0 : w_victim;
  assign w_vic_dirty = w_victim ? (w_v1 & w_d1) : (w_v0 & w_d0);
  assign w_vic_tag   = w_victim ? w_tag1 : w_tag0;

  // Next state, RAM control and response outputs
  always_comb begin
    w_next           = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_hit         = 1'b0;
    resp_way         = 1'b0;
    resp_evict_dirty = 1'b0;
    resp_evict_tag   = '0;
    t0_addr          = r_idx;
    t1_addr          = r_idx;
    t0_din           = '0;
    t1_din           = '0;
    t0_we            = 1'b0;
    t1_we            = 1'b0;
    case (r_state)
      S_INIT: begin
        t0_addr = r_init_cnt;
        t1_addr = r_init_cnt;
        t0_we   = 1'b1;
        t1_we   = 1'b1;
        if (r_init_cnt == AWIDTH'(DEPTH - 1)) w_next = S_IDLE;
      end
      S_IDLE: begin
        req_ready = !reset;
        t0_addr   = req_addr[AWIDTH-1:0];
        t1_addr   = req_addr[AWIDTH-1:0];
        if (req_valid) w_next = S_CMP;
      end
      S_CMP: begin
        w_next = S_IDLE;
        // A reset landing on the CMP cycle drops the request entirely
        if (!reset) begin
          resp_valid = 1'b1;
          resp_hit   = w_hit;
          resp_way   = w_way;
          // Hit rewrite only happens for stores, so dirty is always r_we
          t0_din     = {1'b1, r_we, r_tag};
          t1_din     = {1'b1, r_we, r_tag};
          if (!w_hit) begin
            resp_evict_dirty = w_vic_dirty;
            resp_evict_tag   = w_vic_dirty ? w_vic_tag : '0;
          end
          t0_we = (!w_way) & (!w_hit | r_we);
          t1_we = w_way & (!w_hit | r_we);
        end
      end
      default: w_next = S_INIT;
    endcase
  end

  // State, init counter, request capture and LRU update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_lru      <= '0;
      r_tag      <= '0;
      r_idx      <= '0;
      r_we       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + AWIDTH'(1);
      if (req_valid && req_ready) begin
        r_tag <= req_addr[TWIDTH+AWIDTH-1:AWIDTH];
        r_idx <= req_addr[AWIDTH-1:0];
        r_we  <= req_we;
      end
      if (resp_valid) r_lru[r_idx] <= !w_way;
    end
  end

endmodule

// File: tb/tb_tag_lookup_ctrl_2way.sv
// Bench for tag_lookup_ctrl_2way: behavioural tag RAMs plus a response
// scoreboard fed by the request tasks and drained by a negedge monitor.
module tb_tag_lookup_ctrl_2way;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [14:0] req_addr;
  logic        req_we;
  logic        resp_valid, resp_hit, resp_way, resp_evict_dirty;
  logic [11:0] resp_evict_tag;
  logic [2:0]  t0_addr, t1_addr;
  logic [13:0] t0_din, t1_din, t0_dout, t1_dout;
  logic        t0_we, t1_we;

  typedef struct packed {
    logic        hit;
    logic        way;
    logic        ed;
    logic [11:0] et;
    logic        we0;
    logic        we1;
    logic [13:0] din;
  } exp_t;

  exp_t exp_q[$];
  int   resp_cyc_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always #5 clock = ~clock;

  tag_lookup_ctrl_2way dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_evict_dirty(resp_evict_dirty),
    .resp_evict_tag(resp_evict_tag), .t0_addr(t0_addr), .t1_addr(t1_addr),
    .t0_din(t0_din), .t1_din(t1_din), .t0_we(t0_we), .t1_we(t1_we),
    .t0_dout(t0_dout), .t1_dout(t1_dout)
  );

  // Synchronous-read tag RAMs, pre-filled with all-ones so a missing
  // zero-fill would show up as spurious valid/dirty lines.
  logic [13:0] mem0 [8];
  logic [13:0] mem1 [8];
  logic        filled = 1'b0;
  always @(posedge clock) begin
    if (!filled) begin
      for (int i = 0; i < 8; i++) begin
        mem0[i] <= 14'h3FFF;
        mem1[i] <= 14'h3FFF;
      end
      filled <= 1'b1;
    end else begin
      if (t0_we) mem0[t0_addr] <= t0_din;
      if (t1_we) mem1[t1_addr] <= t1_din;
      t0_dout <= mem0[t0_addr];
      t1_dout <= mem1[t1_addr];
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t mk(input logic hit, input logic way, input logic ed,
                              input logic [11:0] et, input logic we0,
                              input logic we1, input logic [13:0] din);
    exp_t e;
    e.hit = hit; e.way = way; e.ed = ed; e.et = et;
    e.we0 = we0; e.we1 = we1; e.din = din;
    return e;
  endfunction

  task automatic do_req(input logic [11:0] tag, input logic [2:0] idx,
                        input logic we, input exp_t e);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (!req_ready) begin
      $display("FAIL req_ready_timeout tag=%h idx=%0d", tag, idx);
      errors++;
      return;
    end
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_addr  = {tag, idx};
    req_we    = we;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({req_ready, resp_valid, t0_we, t1_we, t0_addr, t0_din} !== {1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 14'd0}) begin
      $display("FAIL reset_values got rdy=%b rv=%b we=%b%b a=%0d din=%h", req_ready, resp_valid, t0_we, t1_we, t0_addr, t0_din);
      errors++;
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      vectors++;
      if ({t0_we, t1_we, t0_addr, t1_addr, t0_din, t1_din, req_ready, resp_valid} !==
          {1'b1, 1'b1, 3'(i), 3'(i), 14'd0, 14'd0, 1'b0, 1'b0}) begin
        $display("FAIL init_cycle%0d got we=%b%b a=%0d/%0d din=%h/%h rdy=%b want we=11 a=%0d din=0 rdy=0",
                 i, t0_we, t1_we, t0_addr, t1_addr, t0_din, t1_din, req_ready, i);
        errors++;
      end
    end
    @(negedge clock);
    vectors++;
    if ({req_ready, t0_we, t1_we} !== 3'b100) begin
      $display("FAIL init_done got rdy=%b we=%b%b want rdy=1 we=00", req_ready, t0_we, t1_we);
      errors++;
    end
  endtask

  task automatic test_miss_then_hit;
    do_req(12'h0A5, 3'd3, 1'b0, mk(1'b0, 1'b0, 1'b0, 12'h0, 1'b1, 1'b0, 14'h20A5));
    do_req(12'h0A5, 3'd3, 1'b0, mk(1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 14'h0));
  endtask

  task automatic test_dirty_eviction;
    do_req(12'h111, 3'd3, 1'b1, mk(1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 1'b1, 14'h3111));
    do_req(12'h222, 3'd3, 1'b0, mk(1'b0, 1'b0, 1'b0, 12'h0,   1'b1, 1'b0, 14'h2222));
    do_req(12'h333, 3'd3, 1'b0, mk(1'b0, 1'b1, 1'b1, 12'h111, 1'b0, 1'b1, 14'h2333));
  endtask

  task automatic test_write_hit;
    do_req(12'h0A5, 3'd5, 1'b0, mk(1'b0, 1'b0, 1'b0, 12'h0,   1'b1, 1'b0, 14'h20A5));
    do_req(12'h0A5, 3'd5, 1'b1, mk(1'b1, 1'b0, 1'b0, 12'h0,   1'b1, 1'b0, 14'h30A5));
    // lru[5]=1 after the write hit: fill way 1, then the next miss must
    // take way 0 and evict the dirty 0x0A5
    do_req(12'h0B0, 3'd5, 1'b0, mk(1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 1'b1, 14'h20B0));
    do_req(12'h0C0, 3'd5, 1'b0, mk(1'b0, 1'b0, 1'b1, 12'h0A5, 1'b1, 1'b0, 14'h20C0));
  endtask

  task automatic test_reset_mid_op;
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    req_valid = 1'b1; req_addr = {12'h222, 3'd3}; req_we = 1'b1;
    @(posedge clock);
    #1 reset = 1'b1; req_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if ({resp_valid, t0_we, t1_we, req_ready} !== 4'b0000) begin
      $display("FAIL midop_drop got rv=%b we=%b%b rdy=%b want 0 0 0 0", resp_valid, t0_we, t1_we, req_ready);
      errors++;
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      vectors++;
      if ({req_ready, t0_we, t0_addr} !== {1'b0, 1'b1, 3'(i)}) begin
        $display("FAIL midop_init%0d got rdy=%b we=%b a=%0d want rdy=0 we=1 a=%0d", i, req_ready, t0_we, t0_addr, i);
        errors++;
      end
    end
    do_req(12'h222, 3'd3, 1'b0, mk(1'b0, 1'b0, 1'b0, 12'h0, 1'b1, 1'b0, 14'h2222));
  endtask

  task automatic test_back_to_back;
    logic [2:0] sets [4];
    int n;
    sets[0] = 3'd0; sets[1] = 3'd1; sets[2] = 3'd2; sets[3] = 3'd6;
    resp_cyc_q.delete();
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(negedge clock);
      while (!req_ready && n < 20) begin
        @(negedge clock);
        n++;
      end
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 12'h0, 1'b1, 1'b0, {2'b10, 12'h100 + 12'(i)}));
      req_valid = 1'b1;
      req_addr  = {12'h100 + 12'(i), sets[i]};
      req_we    = 1'b0;
      @(posedge clock);
    end
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clock);
    vectors++;
    if (resp_cyc_q.size() != 4) begin
      $display("FAIL b2b_count got %0d want 4", resp_cyc_q.size());
      errors++;
    end else begin
      for (int i = 1; i < 4; i++) begin
        vectors++;
        if (resp_cyc_q[i] - resp_cyc_q[i-1] != 2) begin
          $display("FAIL b2b_spacing%0d got %0d cycles want 2", i, resp_cyc_q[i] - resp_cyc_q[i-1]);
          errors++;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    // Response monitor: pops the scoreboard on each resp_valid strobe
    fork
      forever begin
        exp_t e;
        @(negedge clock);
        if (resp_valid) begin
          resp_cyc_q.push_back(cyc);
          vectors++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_resp hit=%b way=%b", resp_hit, resp_way);
            errors++;
          end else begin
            e = exp_q.pop_front();
            if ({resp_hit, resp_way, resp_evict_dirty, resp_evict_tag, t0_we, t1_we} !==
                {e.hit, e.way, e.ed, e.et, e.we0, e.we1}) begin
              $display("FAIL resp got hit=%b way=%b ed=%b et=%h we=%b%b want hit=%b way=%b ed=%b et=%h we=%b%b",
                       resp_hit, resp_way, resp_evict_dirty, resp_evict_tag, t0_we, t1_we,
                       e.hit, e.way, e.ed, e.et, e.we0, e.we1);
              errors++;
            end
            if (e.we0 || e.we1) begin
              vectors++;
              if ((e.we0 ? t0_din : t1_din) !== e.din) begin
                $display("FAIL resp_din got %h want %h", e.we0 ? t0_din : t1_din, e.din);
                errors++;
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_miss_then_hit();
    test_dirty_eviction();
    test_write_hit();
    test_reset_mid_op();
    test_back_to_back();

    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
      errors++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
